// File: rtl/aes_spi_frame_if.sv
// rtl/aes_spi_frame_if.sv - SPI host and AES core signal bundle for aes_spi_frame.
interface aes_spi_frame_if #(
  parameter int KEY_BITS   = 128,
  parameter int BLOCK_BITS = 128
);
  logic                  sck;
  logic                  sdi;
  logic                  load;
  logic                  sdo;
  logic                  done;
  logic                  err;
  logic                  core_start;
  logic [KEY_BITS-1:0]   core_key;
  logic [BLOCK_BITS-1:0] core_plaintext;
  logic                  core_done;
  logic [BLOCK_BITS-1:0] core_cyphertext;

  modport slave (
    input  sck, sdi, load, core_done, core_cyphertext,
    output sdo, done, err, core_start, core_key, core_plaintext
  );

  modport master (
    output sck, sdi, load, core_done, core_cyphertext,
    input  sdo, done, err, core_start, core_key, core_plaintext
  );
endinterface

// File: rtl/aes_spi_frame.sv
// rtl/aes_spi_frame.sv - SPI frame loader/unloader in front of an AES core.
module aes_spi_frame #(
  parameter int KEY_BITS    = 128,
  parameter int BLOCK_BITS  = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  aes_spi_frame_if.slave  bus
);
  localparam int FRAME = BLOCK_BITS + KEY_BITS;
  localparam int CW    = $clog2(FRAME + 2);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_spi_frame: KEY_BITS must be 128, 192 or 256");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("aes_spi_frame: SYNC_STAGES must be >= 2");
  end

  typedef enum logic [2:0] {IDLE, SHIFT_IN, WAIT_CORE, PRESENT, SHIFT_OUT} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, load_sync;
  logic                   sck_d, load_d;
  logic                   sck_s, sdi_s, load_s;
  logic                   sck_rise, sck_fall, load_rise, load_fall;

  logic [FRAME-1:0]       in_sr, in_sr_next;
  logic [CW-1:0]          count, count_inc, count_next;
  logic [BLOCK_BITS-1:0]  out_sr;
  logic                   sdo_q, done_q, err_q, start_q;
  logic [KEY_BITS-1:0]    key_q;
  logic [BLOCK_BITS-1:0]  pt_q;

  logic clr_frame, shift_in, accept, reject, capture, present, shift_out;

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign load_s    = load_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;
  assign load_rise = load_s & ~load_d;
  assign load_fall = ~load_s & load_d;

  // A rise coinciding with the load fall is folded in before the length check.
  assign count_inc  = (count == CW'(FRAME + 1)) ? count : count + CW'(1);
  assign count_next = sck_rise ? count_inc : count;
  assign in_sr_next = sck_rise ? {in_sr[FRAME-2:0], sdi_s} : in_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      sdi_sync  <= '0;
      load_sync <= '0;
      sck_d     <= 1'b0;
      load_d    <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
      load_sync <= {load_sync[SYNC_STAGES-2:0], bus.load};
      sck_d     <= sck_s;
      load_d    <= load_s;
    end
  end

  always_comb begin
    state_next = state;
    clr_frame  = 1'b0;
    shift_in   = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    capture    = 1'b0;
    present    = 1'b0;
    shift_out  = 1'b0;
    case (state)
      IDLE: begin
        if (load_rise) begin
          clr_frame  = 1'b1;
          state_next = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        shift_in = sck_rise;
        if (load_fall) begin
          if (count_next == CW'(FRAME)) begin
            accept     = 1'b1;
            state_next = WAIT_CORE;
          end else begin
            reject     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_CORE, PRESENT, SHIFT_OUT: begin
        // A new load rise abandons any pending or partly read result.
        if (load_rise) begin
          clr_frame  = 1'b1;
          state_next = SHIFT_IN;
        end else if (state == WAIT_CORE) begin
          if (bus.core_done) begin
            capture    = 1'b1;
            state_next = PRESENT;
          end
        end else if (state == PRESENT) begin
          present    = 1'b1;
          state_next = SHIFT_OUT;
        end else begin
          shift_out = sck_fall;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      in_sr   <= '0;
      count   <= '0;
      out_sr  <= '0;
      sdo_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      key_q   <= '0;
      pt_q    <= '0;
    end else begin
      state   <= state_next;
      start_q <= accept;
      if (clr_frame) begin
        count  <= '0;
        err_q  <= 1'b0;
        done_q <= 1'b0;
        sdo_q  <= 1'b0;
        out_sr <= '0;
      end
      if (shift_in) begin
        in_sr <= in_sr_next;
        count <= count_next;
      end
      if (accept) begin
        pt_q  <= in_sr_next[FRAME-1 -: BLOCK_BITS];
        key_q <= in_sr_next[KEY_BITS-1:0];
      end
      if (reject) err_q <= 1'b1;
      if (capture) out_sr <= bus.core_cyphertext;
      if (present) begin
        done_q <= 1'b1;
        sdo_q  <= out_sr[BLOCK_BITS-1];
      end
      if (shift_out) begin
        out_sr <= {out_sr[BLOCK_BITS-2:0], 1'b0};
        sdo_q  <= out_sr[BLOCK_BITS-2];
      end
    end
  end

  assign bus.sdo            = sdo_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.core_start     = start_q;
  assign bus.core_key       = key_q;
  assign bus.core_plaintext = pt_q;
endmodule

// File: tb/tb_aes_spi_frame.sv
// tb/tb_aes_spi_frame.sv - directed bench for aes_spi_frame with 128- and 256-bit keys.
module tb_aes_spi_frame;
  localparam int SS   = 2;
  localparam int HALF = 5;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b0;
  logic sdi = 1'b0;
  logic load = 1'b0;
  logic         core_done128 = 1'b0;
  logic         core_done256 = 1'b0;
  logic [127:0] core_ct128 = '0;
  logic [127:0] core_ct256 = '0;
  int starts128 = 0;
  int starts256 = 0;
  int stale_req = 0;
  int stale_ack = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_spi_frame_if #(.KEY_BITS(128), .BLOCK_BITS(128)) b128 ();
  aes_spi_frame_if #(.KEY_BITS(256), .BLOCK_BITS(128)) b256 ();

  assign b128.sck = sck;
  assign b128.sdi = sdi;
  assign b128.load = load;
  assign b128.core_done = core_done128;
  assign b128.core_cyphertext = core_ct128;
  assign b256.sck = sck;
  assign b256.sdi = sdi;
  assign b256.load = load;
  assign b256.core_done = core_done256;
  assign b256.core_cyphertext = core_ct256;

  aes_spi_frame #(.KEY_BITS(128), .BLOCK_BITS(128), .SYNC_STAGES(SS)) dut128 (
    .clk(clk), .reset(reset), .bus(b128.slave));
  aes_spi_frame #(.KEY_BITS(256), .BLOCK_BITS(128), .SYNC_STAGES(SS)) dut256 (
    .clk(clk), .reset(reset), .bus(b256.slave));

  // Core stand-ins: fixed answer three cycles after each start, plus stale pulses on request.
  always begin
    @(negedge clk);
    if (b128.core_start) begin
      starts128++;
      repeat (3) @(negedge clk);
      core_ct128 = CT128;
      core_done128 = 1'b1;
      @(negedge clk);
      core_done128 = 1'b0;
      core_ct128 = '0;
    end else if (stale_req != stale_ack) begin
      stale_ack = stale_req;
      core_ct128 = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
      core_done128 = 1'b1;
      @(negedge clk);
      core_done128 = 1'b0;
      core_ct128 = '0;
    end
  end

  always begin
    @(negedge clk);
    if (b256.core_start) begin
      starts256++;
      repeat (3) @(negedge clk);
      core_ct256 = CT256;
      core_done256 = 1'b1;
      @(negedge clk);
      core_done256 = 1'b0;
      core_ct256 = '0;
    end
  end

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_up();
    load = 1'b1;
    tick(HALF);
  endtask

  task automatic load_down();
    tick(HALF);
    load = 1'b0;
    tick(SS + 4);
  endtask

  task automatic send_bits(input logic [383:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = data[i];
      tick(HALF);
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic read_bits(input bit sel, input int n, output logic [127:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got = {got[126:0], (sel ? b256.sdo : b128.sdo)};
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
      tick(HALF);
    end
  endtask

  task automatic wait_done(input bit sel, input string tag);
    for (int i = 0; i < 60 && !(sel ? b256.done : b128.done); i++) tick(1);
    check(tag, {383'b0, (sel ? b256.done : b128.done)}, 384'd1);
  endtask

  initial begin
    logic [127:0] got;
    logic [127:0] ct;
    int s0;

    ct = CT128;
    tick(3);
    check("rst_sdo",   {383'b0, b128.sdo}, 384'd0);
    check("rst_done",  {383'b0, b128.done}, 384'd0);
    check("rst_err",   {383'b0, b128.err}, 384'd0);
    check("rst_start", {383'b0, b128.core_start}, 384'd0);
    check("rst_key",   {128'b0, b256.core_key}, 384'd0);
    check("rst_pt",    {256'b0, b128.core_plaintext}, 384'd0);
    reset = 1'b0;
    tick(SS + 2);

    // 1: AES-128 frame and readout
    s0 = starts128;
    load_up();
    send_bits({128'b0, PT, K128}, 256);
    load_down();
    wait_done(1'b0, "t1_done");
    check("t1_starts", 384'(starts128 - s0), 384'd1);
    check("t1_key", {256'b0, b128.core_key}, {256'b0, K128});
    check("t1_pt",  {256'b0, b128.core_plaintext}, {256'b0, PT});
    read_bits(1'b0, 128, got);
    check("t1_ct",  {256'b0, got}, {256'b0, CT128});
    check("t1_sdo_after", {383'b0, b128.sdo}, 384'd0);
    check("t1_done_hold", {383'b0, b128.done}, 384'd1);

    // 2: AES-256 frame and readout
    s0 = starts256;
    load_up();
    send_bits({PT, K256}, 384);
    load_down();
    wait_done(1'b1, "t2_done");
    check("t2_starts", 384'(starts256 - s0), 384'd1);
    check("t2_key", {128'b0, b256.core_key}, {128'b0, K256});
    check("t2_pt",  {256'b0, b256.core_plaintext}, {256'b0, PT});
    read_bits(1'b1, 128, got);
    check("t2_ct",  {256'b0, got}, {256'b0, CT256});

    // 3: short frame
    s0 = starts128;
    load_up();
    send_bits({128'b0, PT, K128}, 255);
    load_down();
    tick(10);
    check("t3_err",    {383'b0, b128.err}, 384'd1);
    check("t3_starts", 384'(starts128 - s0), 384'd0);
    check("t3_done",   {383'b0, b128.done}, 384'd0);

    // 4: long frame
    load_up();
    check("t4_err_clear", {383'b0, b128.err}, 384'd0);
    send_bits({127'b0, PT, K128, 1'b1}, 257);
    load_down();
    tick(10);
    check("t4_err",    {383'b0, b128.err}, 384'd1);
    check("t4_starts", 384'(starts128 - s0), 384'd0);
    check("t4_key_hold", {256'b0, b128.core_key}, {256'b0, K128});

    // 5: good frame clears the error
    load_up();
    check("t5_err_clear", {383'b0, b128.err}, 384'd0);
    send_bits({128'b0, PT, K128}, 256);
    load_down();
    wait_done(1'b0, "t5_done");
    check("t5_err", {383'b0, b128.err}, 384'd0);

    // 6: abort after 40 bits of readout
    read_bits(1'b0, 40, got);
    check("t6_prefix", {344'b0, got[39:0]}, {344'b0, ct[127:88]});
    load_up();
    check("t6_done_abort", {383'b0, b128.done}, 384'd0);
    check("t6_sdo_abort",  {383'b0, b128.sdo}, 384'd0);
    send_bits({128'b0, PT, K128}, 256);
    load_down();
    wait_done(1'b0, "t6_done");
    read_bits(1'b0, 128, got);
    check("t6_ct", {256'b0, got}, {256'b0, CT128});

    // 7: stale core_done during shift-in
    s0 = starts128;
    load_up();
    stale_req++;
    tick(6);
    check("t7_done_stale", {383'b0, b128.done}, 384'd0);
    send_bits({128'b0, PT, K128}, 256);
    load_down();
    wait_done(1'b0, "t7_done");
    check("t7_starts", 384'(starts128 - s0), 384'd1);
    read_bits(1'b0, 128, got);
    check("t7_ct", {256'b0, got}, {256'b0, CT128});

    // 8: reset mid-frame
    load_up();
    send_bits({128'b0, PT, K128}, 100);
    reset = 1'b1;
    tick(1);
    check("t8_done", {383'b0, b128.done}, 384'd0);
    check("t8_sdo",  {383'b0, b128.sdo}, 384'd0);
    check("t8_err",  {383'b0, b128.err}, 384'd0);
    check("t8_key",  {256'b0, b128.core_key}, 384'd0);
    check("t8_pt",   {256'b0, b128.core_plaintext}, 384'd0);
    load = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(SS + 4);

    // 9: fresh frame after reset
    s0 = starts128;
    load_up();
    send_bits({128'b0, PT, K128}, 256);
    load_down();
    wait_done(1'b0, "t9_done");
    check("t9_starts", 384'(starts128 - s0), 384'd1);
    check("t9_key", {256'b0, b128.core_key}, {256'b0, K128});
    check("t9_pt",  {256'b0, b128.core_plaintext}, {256'b0, PT});
    read_bits(1'b0, 128, got);
    check("t9_ct", {256'b0, got}, {256'b0, CT128});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
